// File: rtl/ifu_iccm_arb_pkg.sv
// Shared types for the ICCM port arbiter: DMA size codes, RMW states and the
// 39-bit ICCM word layout with its SECDED coverage masks.
package ifu_iccm_arb_pkg;
  localparam int ECC_W = 7;

  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;
  localparam logic [2:0] SZ_DWORD = 3'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RMW_RD, ST_RMW_MRG, ST_RMW_WR} rmw_st_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IFC, OWN_DMA} own_e;

  typedef struct packed {
    logic [ECC_W-1:0] ecc;
    logic [31:0]      data;
  } iccm_word_t;

  typedef struct packed {
    logic [2:0]  size;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } rmw_req_t;

  // Hamming layout: data bits occupy the non-power-of-two codeword positions
  // 3..38 in order; check bit k covers positions with bit k set.
  function automatic logic [31:0] ecc_cov_mask(input int k);
    int j;
    ecc_cov_mask = '0;
    j = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        ecc_cov_mask[j] = p[k];
        j++;
      end
    end
  endfunction
endpackage

// File: rtl/iccm_ecc_gen.sv
// Combinational 32->7 SECDED generator: six Hamming checks plus overall parity.
module iccm_ecc_gen
  import ifu_iccm_arb_pkg::*;
(
  input  logic [31:0]      data,
  output logic [ECC_W-1:0] ecc
);
  logic [5:0] chk;

  for (genvar k = 0; k < 6; k++) begin : g_chk
    assign chk[k] = ^(data & ecc_cov_mask(k));
  end

  assign ecc = {^{data, chk}, chk};
endmodule

// File: rtl/ifu_iccm_arb.sv
// Arbitrates the single ICCM port between fetch reads and DMA, sequencing
// read-modify-write for DMA byte/half writes with ECC regeneration.
module ifu_iccm_arb
  import ifu_iccm_arb_pkg::*;
#(
  parameter int ICCM_BITS  = 19,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ifc_rd_req,
  input  logic [ICCM_BITS-3:0]   ifc_rd_addr,
  output logic                   ifc_rd_gnt,
  output logic                   ifc_rd_valid,
  output logic [155:0]           ifc_rd_data,
  input  logic                   dma_req,
  input  logic                   dma_write,
  input  logic [2:0]             dma_size,
  input  logic [ICCM_BITS-1:0]   dma_addr,
  input  logic [63:0]            dma_wdata,
  output logic                   dma_gnt,
  output logic                   dma_rd_valid,
  output logic [63:0]            dma_rd_data,
  output logic                   iccm_rden,
  output logic                   iccm_wren,
  output logic [ICCM_BITS-3:0]   iccm_rw_addr,
  output logic [2:0]             iccm_wr_size,
  output logic [77:0]            iccm_wr_data,
  input  logic [155:0]           iccm_rd_data
);
  localparam int         AW         = ICCM_BITS - 2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  rmw_st_e    st_q, st_d;
  own_e       own_q, own_d;
  logic [3:0] starve_q;
  logic [AW-1:0] rmw_addr_q;
  rmw_req_t   rmw_q;
  iccm_word_t mrg_q;
  logic [1:0] rd_sel_q;
  logic       rd_dw_q;

  iccm_word_t [3:0]        rd_w;
  logic [AW-1:0]           dma_waddr;
  logic [31:0]             old_word, mrg_data;
  logic                    fetch_force, dma_win;
  logic [1:0][31:0]        ecc_din;
  logic [1:0][ECC_W-1:0]   ecc_dout;

  assign rd_w      = iccm_rd_data;
  assign dma_waddr = dma_addr[ICCM_BITS-1:2];

  // lo generator is shared between direct writes and the RMW merge result
  assign ecc_din[0] = (st_q == ST_RMW_MRG) ? mrg_data : dma_wdata[31:0];
  assign ecc_din[1] = dma_wdata[63:32];

  iccm_ecc_gen u_ecc [1:0] (
    .data (ecc_din),
    .ecc  (ecc_dout)
  );

  always_comb begin
    old_word = rd_w[rmw_addr_q[1:0]].data;
    mrg_data = old_word;
    if (rmw_q.size == SZ_HALF) mrg_data[16*rmw_q.lane[1] +: 16] = rmw_q.wdata;
    else                       mrg_data[8*rmw_q.lane +: 8]      = rmw_q.wdata[7:0];
  end

  always_comb begin
    st_d         = st_q;
    own_d        = OWN_NONE;
    ifc_rd_gnt   = 1'b0;
    dma_gnt      = 1'b0;
    iccm_rden    = 1'b0;
    iccm_wren    = 1'b0;
    iccm_rw_addr = '0;
    iccm_wr_size = '0;
    iccm_wr_data = '0;
    fetch_force  = ifc_rd_req && (starve_q == STARVE_LIM);
    dma_win      = dma_req && !fetch_force;
    unique case (st_q)
      ST_IDLE: begin
        if (dma_win) begin
          dma_gnt = 1'b1;
          if (!dma_write) begin
            iccm_rden    = 1'b1;
            iccm_rw_addr = dma_waddr;
            own_d        = OWN_DMA;
          end else if (dma_size == SZ_BYTE || dma_size == SZ_HALF) begin
            st_d = ST_RMW_RD;
          end else if (dma_size == SZ_WORD) begin
            iccm_wren    = 1'b1;
            iccm_wr_size = SZ_WORD;
            iccm_rw_addr = dma_waddr;
            iccm_wr_data = {ecc_dout[0], dma_wdata[31:0], ecc_dout[0], dma_wdata[31:0]};
          end else begin
            iccm_wren    = 1'b1;
            iccm_wr_size = SZ_DWORD;
            iccm_rw_addr = {dma_waddr[AW-1:1], 1'b0};
            iccm_wr_data = {ecc_dout[1], dma_wdata[63:32], ecc_dout[0], dma_wdata[31:0]};
          end
        end else if (ifc_rd_req) begin
          ifc_rd_gnt   = 1'b1;
          iccm_rden    = 1'b1;
          iccm_rw_addr = ifc_rd_addr;
          own_d        = OWN_IFC;
        end
      end
      ST_RMW_RD: begin
        iccm_rden    = 1'b1;
        iccm_rw_addr = rmw_addr_q;
        st_d         = ST_RMW_MRG;
      end
      ST_RMW_MRG: st_d = ST_RMW_WR;
      ST_RMW_WR: begin
        iccm_wren    = 1'b1;
        iccm_wr_size = SZ_WORD;
        iccm_rw_addr = rmw_addr_q;
        iccm_wr_data = {mrg_q, mrg_q};
        st_d         = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
    // reset kills strobes immediately so an aborted RMW never writes
    if (rst) begin
      ifc_rd_gnt   = 1'b0;
      dma_gnt      = 1'b0;
      iccm_rden    = 1'b0;
      iccm_wren    = 1'b0;
      iccm_rw_addr = '0;
      iccm_wr_size = '0;
      iccm_wr_data = '0;
    end
  end

  always_comb begin
    ifc_rd_valid = !rst && (own_q == OWN_IFC);
    dma_rd_valid = !rst && (own_q == OWN_DMA);
    ifc_rd_data  = ifc_rd_valid ? iccm_rd_data : '0;
    dma_rd_data  = '0;
    if (dma_rd_valid)
      dma_rd_data = {rd_dw_q ? rd_w[rd_sel_q + 2'd1].data : 32'b0, rd_w[rd_sel_q].data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      own_q      <= OWN_NONE;
      starve_q   <= '0;
      rmw_addr_q <= '0;
      rmw_q      <= '0;
      mrg_q      <= '0;
      rd_sel_q   <= '0;
      rd_dw_q    <= 1'b0;
    end else begin
      st_q  <= st_d;
      own_q <= own_d;
      if (ifc_rd_gnt)                                starve_q <= '0;
      else if (ifc_rd_req && starve_q != STARVE_LIM) starve_q <= starve_q + 4'd1;
      if (dma_gnt) begin
        rmw_addr_q <= dma_waddr;
        rmw_q      <= '{size: dma_size, lane: dma_addr[1:0], wdata: dma_wdata[15:0]};
        rd_sel_q   <= dma_addr[3:2];
        rd_dw_q    <= (dma_size >= SZ_DWORD);
      end
      if (st_q == ST_RMW_MRG) mrg_q <= '{ecc: ecc_dout[0], data: mrg_data};
    end
  end
endmodule
